// File: rtl/ks_sum_normalizer_if.sv
// Handshake bundle between the Kogge-Stone prefix stage, the sum normaliser and the
// exponent-adjust stage. The normaliser is the slave; the producer/consumer side is the master.
interface ks_sum_normalizer_if #(
  parameter int unsigned W   = 25,
  parameter int unsigned LZW = 5
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_GG;
  logic [W-1:0]   in_P0;
  logic           in_sign;

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_mant;
  logic [LZW-1:0] out_lzc;
  logic           out_ovf;
  logic           out_sticky;
  logic           out_zero;
  logic           out_sign;

  modport master (
    output in_valid, in_GG, in_P0, in_sign, out_ready,
    input  in_ready, out_valid, out_mant, out_lzc, out_ovf, out_sticky, out_zero, out_sign
  );

  modport slave (
    input  in_valid, in_GG, in_P0, in_sign, out_ready,
    output in_ready, out_valid, out_mant, out_lzc, out_ovf, out_sticky, out_zero, out_sign
  );
endinterface

// File: rtl/ks_sum_normalizer.sv
// Forms the W+1-bit sum from the final prefix-stage carries and propagates, then normalises it
// (overflow right-shift or leading-zero left-shift) through a two-stage valid/ready pipeline.
module ks_sum_normalizer #(
  parameter int unsigned W   = 25,
  parameter int unsigned LZW = 5
) (
  input logic                clock,
  input logic                reset,
  ks_sum_normalizer_if.slave bus
);

  // Stage A: raw sum
  logic [W:0]     a_r_q;
  logic           a_sign_q;
  logic           va_q, va_d;

  // Stage B: normalised result driving the outputs
  logic [W-1:0]   mant_q;
  logic [LZW-1:0] lzc_q;
  logic           ovf_q, sticky_q, zero_q, sign_q;
  logic           vb_q, vb_d;

  logic           adv_b, load_a, load_b;
  logic [W-1:0]   sum_s;
  logic [W-1:0]   a_s;
  logic [LZW-1:0] lz_cnt;

  logic [W-1:0]   nrm_mant;
  logic [LZW-1:0] nrm_lzc;
  logic           nrm_ovf, nrm_sticky, nrm_zero, nrm_sign;

  assign adv_b        = !vb_q || bus.out_ready;
  assign bus.in_ready = !va_q || adv_b;
  assign load_a       = bus.in_valid && bus.in_ready;
  assign load_b       = adv_b && va_q;

  // Carry into bit i is the group generate of bit i-1; bit 0 has no carry in.
  assign sum_s = bus.in_P0 ^ {bus.in_GG[W-2:0], 1'b0};
  assign a_s   = a_r_q[W-1:0];

  always_comb begin
    va_d = va_q;
    vb_d = vb_q;
    if (load_a) begin
      va_d = 1'b1;
    end else if (load_b) begin
      va_d = 1'b0;
    end
    if (load_b) begin
      vb_d = 1'b1;
    end else if (bus.out_ready) begin
      vb_d = 1'b0;
    end
  end

  // Highest set bit wins since the scan runs LSB to MSB.
  always_comb begin
    lz_cnt = '0;
    for (int unsigned k = 0; k < W; k++) begin
      if (a_s[k]) begin
        lz_cnt = LZW'(W - 1 - k);
      end
    end
  end

  always_comb begin
    nrm_mant   = '0;
    nrm_lzc    = '0;
    nrm_ovf    = 1'b0;
    nrm_sticky = 1'b0;
    nrm_zero   = 1'b0;
    nrm_sign   = a_sign_q;
    if (a_r_q[W]) begin
      nrm_mant   = a_r_q[W:1];
      nrm_sticky = a_r_q[0];
      nrm_ovf    = 1'b1;
    end else if (a_s == '0) begin
      nrm_zero = 1'b1;
      nrm_lzc  = LZW'(W);
      nrm_sign = 1'b0;
    end else begin
      nrm_lzc  = lz_cnt;
      nrm_mant = a_s << lz_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (load_a) begin
      a_r_q    <= {bus.in_GG[W-1], sum_s};
      a_sign_q <= bus.in_sign;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      va_q     <= 1'b0;
      vb_q     <= 1'b0;
      mant_q   <= '0;
      lzc_q    <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
      if (load_b) begin
        mant_q   <= nrm_mant;
        lzc_q    <= nrm_lzc;
        ovf_q    <= nrm_ovf;
        sticky_q <= nrm_sticky;
        zero_q   <= nrm_zero;
        sign_q   <= nrm_sign;
      end
    end
  end

  assign bus.out_valid  = vb_q;
  assign bus.out_mant   = mant_q;
  assign bus.out_lzc    = lzc_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_sticky = sticky_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_sign   = sign_q;

endmodule

// File: doc/ks_sum_normalizer.md
Name: ks_sum_normalizer

Overview:
- Consumer end of the pipelined Kogge-Stone prefix network in the floating-point MAC datapath.
- Takes the final group-generate vector (carry into each bit) and the bitwise propagate vector from the last prefix stage, forms the W+1-bit sum, and normalises it (overflow right-shift or leading-zero left-shift).
- Two-stage pipeline with valid/ready handshake; feeds the exponent-adjust/rounding stage.

Parameters:
- W, 25, mantissa datapath width (prefix vector width).
- LZW, 5, width of the shift-count field; must satisfy 2^LZW > W.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  prefix-stage result valid.
- in_ready  output  1  block can accept in_* this cycle.
- in_GG  input  W  group generate G[i:0]; in_GG[i] is the carry out of bit i.
- in_P0  input  W  bitwise propagate a[i]^b[i].
- in_sign  input  1  result sign carried alongside the datapath.
- out_valid  output  1  normalised result valid.
- out_ready  input  1  downstream accepts.
- out_mant  output  W  normalised mantissa, MSB set unless out_zero.
- out_lzc  output  LZW  left-shift amount applied (0..W).
- out_ovf  output  1  sum overflowed; mantissa right-shifted by 1.
- out_sticky  output  1  bit shifted out on overflow.
- out_zero  output  1  sum is exactly zero.
- out_sign  output  1  sign; forced 0 when out_zero.

Behaviour:
- Sum formation (stage A input, combinational):
  - S[0] = P0[0].
  - S[i] = P0[i] ^ GG[i-1] for i = 1..W-1.
  - R = {GG[W-1], S}, W+1 bits.
- Stage A register captures R and sign; vA marks it valid.
- Stage B register captures the normalised fields; vB drives out_valid.
- Normalisation, computed from stage A:
  - If R[W] = 1: out_ovf = 1, out_mant = R[W:1], out_sticky = R[0], out_lzc = 0.
  - Else if S = 0: out_zero = 1, out_mant = 0, out_lzc = W, out_sign = 0, out_ovf = 0, out_sticky = 0.
  - Else: out_lzc = number of leading zeros of S; out_mant = S << out_lzc; out_ovf = 0; out_sticky = 0.
- Handshake:
  - advB = !vB || out_ready.
  - in_ready = !vA || advB (combinational; may depend on out_ready).
  - A transfer occurs when valid && ready on the same edge.
  - Stage A loads on an input transfer. When A drains into B with no new input, vA clears.
  - Stage B loads when advB && vA. When out_ready with !vA, vB clears.
- Latency: 2 cycles from input transfer to out_valid when not stalled. Throughput: 1 per cycle.
- Stall: while out_valid && !out_ready, all out_* stay stable. At most 2 items are buffered (A and B), then in_ready = 0. No data is lost or duplicated, and order is preserved.
- Simultaneous events: input accept and output drain in the same cycle are both performed.
- Reset:
  - Synchronous, highest priority; vA = vB = 0 and every output register = 0 (out_valid=0, out_mant=0, out_lzc=0, out_ovf=0, out_sticky=0, out_zero=0, out_sign=0).
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-stall discards buffered items.
- Data registers need not reset beyond the outputs, but out_* must read 0 while out_valid = 0 after reset.

Test Plan:
- 1+1: in_P0=0, in_GG=0x0000001, in_sign=0 -> 2 cycles later out_mant=0x1000000, out_lzc=23, out_ovf=0, out_zero=0.
- Overflow: in_P0=0, in_GG=0x1000000 -> out_ovf=1, out_mant=0x1000000, out_sticky=0, out_lzc=0.
- Overflow with sticky: in_P0=0x0000001, in_GG=0x1000000 -> out_mant=0x1000000, out_sticky=1.
- Zero: in_P0=0, in_GG=0, in_sign=1 -> out_zero=1, out_lzc=25, out_mant=0, out_sign=0.
- Back-pressure: out_ready=0, present 3 back-to-back items -> first 2 accepted, then in_ready=0; outputs stable until out_ready=1, then all 3 emerge in order with no gaps.
- Reset mid-stream: assert reset with vA=vB=1 -> next cycle out_valid=0, all outputs 0, in_ready=1; the next input appears 2 cycles after acceptance.
